// File: rtl/serial_adder_pkg.sv
// Shared types for the bit-serial adder/subtractor.
package serial_adder_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/fulladder.sv
// 1-bit full adder cell.
module fulladder (
  input  logic a_i,
  input  logic b_i,
  input  logic carry_i,
  output logic sum_o,
  output logic carry_o
);

  assign sum_o   = a_i ^ b_i ^ carry_i;
  assign carry_o = (a_i & b_i) | (carry_i & (a_i ^ b_i));

endmodule

// File: rtl/serial_adder.sv
// Bit-serial WIDTH-bit add/subtract: one fulladder, one bit per clock, LSB first.
//
// state | meaning
// IDLE  | ready for a request, outputs hold the previous result
// RUN   | one operand bit per edge through the fulladder
// DONE  | result final, valid_o pulses for one cycle
module serial_adder
  import serial_adder_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             req_i,
  output logic             ready_o,
  input  logic             sub_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic             carry_i,
  output logic [WIDTH-1:0] sum_o,
  output logic             carry_o,
  output logic             overflow_o,
  output logic             valid_o
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);
  localparam logic [CW-1:0] PREV_BIT = CW'(WIDTH - 2);

  state_t           r_state;
  state_t           w_state_next;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-1:0] r_sum;
  logic             r_carry;
  logic             r_msb_cin;
  logic             r_carry_out;
  logic             r_ovf;
  logic [CW-1:0]    r_bit_cnt;
  logic             w_sum_bit;
  logic             w_carry_bit;
  logic             w_last_bit;

  fulladder u_fa (
    .a_i     (r_a[0]),
    .b_i     (r_b[0]),
    .carry_i (r_carry),
    .sum_o   (w_sum_bit),
    .carry_o (w_carry_bit)
  );

  assign w_last_bit = (r_bit_cnt == LAST_BIT);

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE:    if (req_i) w_state_next = RUN;
      RUN:     if (w_last_bit) w_state_next = DONE;
      DONE:    w_state_next = IDLE;
      default: w_state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state     <= IDLE;
      r_a         <= '0;
      r_b         <= '0;
      r_sum       <= '0;
      r_carry     <= 1'b0;
      r_msb_cin   <= 1'b0;
      r_carry_out <= 1'b0;
      r_ovf       <= 1'b0;
      r_bit_cnt   <= '0;
    end else begin
      r_state <= w_state_next;
      case (r_state)
        IDLE: begin
          if (req_i) begin
            r_a       <= a_i;
            r_b       <= sub_i ? ~b_i : b_i;
            r_carry   <= sub_i ? 1'b1 : carry_i;
            r_bit_cnt <= '0;
          end
        end
        RUN: begin
          r_a     <= r_a >> 1;
          r_b     <= r_b >> 1;
          r_sum   <= {w_sum_bit, r_sum[WIDTH-1:1]};
          r_carry <= w_carry_bit;
          // Carry produced by bit WIDTH-2 is the carry into the MSB.
          if (r_bit_cnt == PREV_BIT) r_msb_cin <= w_carry_bit;
          if (w_last_bit) begin
            r_carry_out <= w_carry_bit;
            r_ovf       <= r_msb_cin ^ w_carry_bit;
          end else begin
            r_bit_cnt <= r_bit_cnt + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign ready_o    = (r_state == IDLE);
  assign valid_o    = (r_state == DONE);
  assign sum_o      = r_sum;
  assign carry_o    = r_carry_out;
  assign overflow_o = r_ovf;

endmodule

// File: tb/tb_serial_adder.sv
// Scoreboard bench for serial_adder (WIDTH = 32).
module tb_serial_adder;

  localparam int WIDTH = 32;

  logic             clk_i = 1'b0;
  logic             rst_i;
  logic             req_i;
  logic             ready_o;
  logic             sub_i;
  logic [WIDTH-1:0] a_i;
  logic [WIDTH-1:0] b_i;
  logic             carry_i;
  logic [WIDTH-1:0] sum_o;
  logic             carry_o;
  logic             overflow_o;
  logic             valid_o;

  serial_adder #(.WIDTH(WIDTH)) dut (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .req_i      (req_i),
    .ready_o    (ready_o),
    .sub_i      (sub_i),
    .a_i        (a_i),
    .b_i        (b_i),
    .carry_i    (carry_i),
    .sum_o      (sum_o),
    .carry_o    (carry_o),
    .overflow_o (overflow_o),
    .valid_o    (valid_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic [WIDTH-1:0] sum;
    logic             carry;
    logic             ovf;
    int               acc_cyc;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   valid_cnt = 0;
  int   last_accept = 0;
  int   prev_accept = 0;

  function automatic exp_t model(logic [WIDTH-1:0] a, logic [WIDTH-1:0] b,
                                 logic sub, logic cin, int acc);
    exp_t           e;
    logic [WIDTH-1:0] bb;
    logic           c0;
    logic [WIDTH:0] r;
    bb = sub ? ~b : b;
    c0 = sub ? 1'b1 : cin;
    r  = {1'b0, a} + {1'b0, bb} + {{WIDTH{1'b0}}, c0};
    e.sum     = r[WIDTH-1:0];
    e.carry   = r[WIDTH];
    e.ovf     = (a[WIDTH-1] == bb[WIDTH-1]) && (r[WIDTH-1] != a[WIDTH-1]);
    e.acc_cyc = acc;
    return e;
  endfunction

  initial forever begin
    @(posedge clk_i);
    cyc = cyc + 1;
  end

  // Pushes expectations on accept, pops and compares on valid_o.
  initial forever begin
    exp_t e;
    @(negedge clk_i);
    #2;
    if (rst_i === 1'b0 && ready_o === 1'b1 && req_i === 1'b1) begin
      prev_accept = last_accept;
      last_accept = cyc + 1;
      sb.push_back(model(a_i, b_i, sub_i, carry_i, cyc + 1));
    end
    if (valid_o === 1'b1) begin
      valid_cnt++;
      if (sb.size() == 0) begin
        checks++; errors++;
        $display("FAIL unexpected_valid: valid_o seen with no pending operation at cycle %0d", cyc);
      end else begin
        e = sb.pop_front();
        checks++;
        if (sum_o !== e.sum) begin
          errors++;
          $display("FAIL sum: got %h expected %h", sum_o, e.sum);
        end
        checks++;
        if (carry_o !== e.carry) begin
          errors++;
          $display("FAIL carry: got %b expected %b (sum %h)", carry_o, e.carry, e.sum);
        end
        checks++;
        if (overflow_o !== e.ovf) begin
          errors++;
          $display("FAIL overflow: got %b expected %b (sum %h)", overflow_o, e.ovf, e.sum);
        end
        checks++;
        if (cyc - e.acc_cyc !== WIDTH) begin
          errors++;
          $display("FAIL latency: got %0d expected %0d", cyc - e.acc_cyc, WIDTH);
        end
      end
    end
  end

  task automatic wait_ready();
    int n = 0;
    while (ready_o !== 1'b1 && n < 50) begin
      @(negedge clk_i);
      n++;
    end
    if (ready_o !== 1'b1) begin
      checks++; errors++;
      $display("FAIL ready_timeout: ready_o=%b expected 1", ready_o);
    end
  endtask

  task automatic wait_valid();
    int n = 0;
    while (valid_o !== 1'b1 && n < 50) begin
      @(negedge clk_i);
      n++;
    end
    if (valid_o !== 1'b1) begin
      checks++; errors++;
      $display("FAIL valid_timeout: valid_o=%b expected 1", valid_o);
    end
  endtask

  task automatic start_op(logic [WIDTH-1:0] a, logic [WIDTH-1:0] b, logic sub, logic cin);
    @(negedge clk_i);
    wait_ready();
    a_i = a; b_i = b; sub_i = sub; carry_i = cin; req_i = 1'b1;
    @(negedge clk_i);
    req_i = 1'b0;
  endtask

  task automatic run_op(logic [WIDTH-1:0] a, logic [WIDTH-1:0] b, logic sub, logic cin);
    start_op(a, b, sub, cin);
    wait_valid();
    @(negedge clk_i);
  endtask

  task automatic test_reset();
    rst_i = 1'b1; req_i = 1'b1; sub_i = 1'b0; carry_i = 1'b1;
    a_i = 32'h1234_5678; b_i = 32'h1111_1111;
    repeat (3) @(negedge clk_i);
    checks++; if (ready_o !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b expected 1", ready_o); end
    checks++; if (valid_o !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b expected 0", valid_o); end
    checks++; if (sum_o !== '0) begin errors++; $display("FAIL reset_sum: got %h expected 0", sum_o); end
    checks++; if (carry_o !== 1'b0) begin errors++; $display("FAIL reset_carry: got %b expected 0", carry_o); end
    checks++; if (overflow_o !== 1'b0) begin errors++; $display("FAIL reset_ovf: got %b expected 0", overflow_o); end
    rst_i = 1'b0; req_i = 1'b0;
    repeat (40) @(negedge clk_i);
    checks++;
    if (valid_cnt !== 0) begin
      errors++;
      $display("FAIL reset_req_dropped: valid pulses %0d expected 0", valid_cnt);
    end
  endtask

  task automatic test_add();
    run_op(32'd5, 32'd7, 1'b0, 1'b0);
    run_op(32'hFFFF_FFFF, 32'h0000_0000, 1'b0, 1'b1);
    run_op(32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0);
    run_op(32'h8000_0000, 32'h8000_0000, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++)
      run_op($urandom, $urandom, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
  endtask

  task automatic test_sub();
    run_op(32'd5, 32'd7, 1'b1, 1'b0);
    run_op(32'd7, 32'd5, 1'b1, 1'b1);
    run_op(32'h8000_0000, 32'd1, 1'b1, 1'b0);
    run_op(32'd9, 32'd9, 1'b1, 1'b0);
  endtask

  task automatic test_ignore_req();
    int vc0;
    vc0 = valid_cnt;
    start_op(32'd100, 32'd23, 1'b0, 1'b0);
    repeat (3) @(negedge clk_i);
    a_i = 32'hAAAA_0000; b_i = 32'h0000_5555; sub_i = 1'b1; req_i = 1'b1;
    repeat (2) @(negedge clk_i);
    req_i = 1'b0;
    wait_valid();
    repeat (40) @(negedge clk_i);
    checks++;
    if (valid_cnt - vc0 !== 1) begin
      errors++;
      $display("FAIL ignore_req_pulses: got %0d expected 1", valid_cnt - vc0);
    end
    checks++;
    if (sum_o !== 32'd123) begin
      errors++;
      $display("FAIL ignore_req_hold: got %h expected %h", sum_o, 32'd123);
    end
  endtask

  task automatic test_reset_mid_run();
    int vc0;
    start_op(32'hDEAD_BEEF, 32'h0123_4567, 1'b0, 1'b0);
    repeat (10) @(negedge clk_i);
    rst_i = 1'b1; req_i = 1'b1;
    @(negedge clk_i);
    rst_i = 1'b0; req_i = 1'b0;
    checks++; if (ready_o !== 1'b1) begin errors++; $display("FAIL abort_ready: got %b expected 1", ready_o); end
    checks++; if (sum_o !== '0) begin errors++; $display("FAIL abort_sum: got %h expected 0", sum_o); end
    checks++; if (valid_o !== 1'b0) begin errors++; $display("FAIL abort_valid: got %b expected 0", valid_o); end
    sb.delete();
    vc0 = valid_cnt;
    repeat (40) @(negedge clk_i);
    checks++;
    if (valid_cnt !== vc0) begin
      errors++;
      $display("FAIL abort_no_pulse: pulses %0d expected 0", valid_cnt - vc0);
    end
    run_op(32'd1, 32'd1, 1'b0, 1'b0);
    checks++;
    if (sum_o !== 32'd2) begin
      errors++;
      $display("FAIL after_abort_sum: got %h expected 2", sum_o);
    end
  endtask

  task automatic test_back_to_back();
    int n;
    @(negedge clk_i);
    wait_ready();
    a_i = 32'h0F0F_0F0F; b_i = 32'h1010_1010; sub_i = 1'b0; carry_i = 1'b1; req_i = 1'b1;
    wait_valid();
    a_i = 32'h4000_0000; b_i = 32'hC000_0000; sub_i = 1'b1;
    n = 0;
    while (ready_o !== 1'b1 && n < 10) begin
      @(negedge clk_i);
      n++;
    end
    @(negedge clk_i);
    req_i = 1'b0;
    checks++;
    if (last_accept - prev_accept !== WIDTH + 2) begin
      errors++;
      $display("FAIL back_to_back_interval: got %0d expected %0d", last_accept - prev_accept, WIDTH + 2);
    end
    wait_valid();
    @(negedge clk_i);
  endtask

  initial begin
    test_reset();
    test_add();
    test_sub();
    test_ignore_req();
    test_reset_mid_run();
    test_back_to_back();
    repeat (3) @(negedge clk_i);
    checks++;
    if (sb.size() !== 0) begin
      errors++;
      $display("FAIL pending_results: got %0d outstanding expected 0", sb.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
